// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width/sign codes
// and the LSU state encoding, used by both the core and the LSU.
package load_store_unit_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
//   is_store, funct3, addr_lo : operation being classified
//   wdata                     : store data (rs2)
//   mem_rdata                 : raw read word from memory
//   misaligned                : alignment fault or illegal funct3 for the op
//   wstrb, wdata_lanes        : store byte strobes and lane-replicated data
//   rdata_ext                 : selected byte/halfword, sign/zero-extended
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_rdata,
   output logic        misaligned,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_lanes,
   output logic [31:0] rdata_ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = mem_rdata[{addr_lo, 3'b000} +: 8];
   assign half_sel = mem_rdata[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      misaligned  = 1'b0;
      wstrb       = 4'b1111;
      wdata_lanes = wdata;
      rdata_ext   = mem_rdata;
      case (funct3)
         F3_LB: begin
            wstrb       = 4'b0001 << addr_lo;
            wdata_lanes = {4{wdata[7:0]}};
            rdata_ext   = {{24{byte_sel[7]}}, byte_sel};
         end
         F3_LH: begin
            misaligned  = addr_lo[0];
            wstrb       = 4'b0011 << addr_lo;
            wdata_lanes = {2{wdata[15:0]}};
            rdata_ext   = {{16{half_sel[15]}}, half_sel};
         end
         F3_LW: begin
            misaligned  = |addr_lo;
         end
         // unsigned variants exist only for loads
         F3_LBU: begin
            misaligned  = is_store;
            rdata_ext   = {24'h0, byte_sel};
         end
         F3_LHU: begin
            misaligned  = is_store | addr_lo[0];
            rdata_ext   = {16'h0, half_sel};
         end
         default: begin
            misaligned  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between execute stage and data memory.
//   i_clk, i_rst_n (sync, active-low)
//   i_valid/o_ready, i_is_store, i_funct3, i_addr, i_wdata : request from execute
//   o_mem_valid/i_mem_ready, o_mem_addr/we/wstrb/wdata    : memory request
//   i_mem_rvalid, i_mem_rdata                             : memory read response
//   o_done, o_rdata, o_misaligned                         : completion to core
//
// state | meaning
// IDLE  | ready for a new operation
// REQ   | memory request presented, waiting for i_mem_ready
// RSP   | load issued, waiting for i_mem_rvalid
// DONE  | one-cycle completion pulse (o_done)
module load_store_unit
   import load_store_unit_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic        i_is_store,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_mem_valid,
   input  logic        i_mem_ready,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_we,
   output logic [3:0]  o_mem_wstrb,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata,
   output logic        o_done,
   output logic [31:0] o_rdata,
   output logic        o_misaligned
);

   lsu_state_t  state;
   logic        is_store_q;
   logic [2:0]  funct3_q;
   logic [1:0]  addr_lo_q;

   logic        sel_is_store;
   logic [2:0]  sel_funct3;
   logic [1:0]  sel_addr_lo;
   logic        al_misaligned;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;

   // One aligner serves both directions: it classifies the live request in
   // IDLE and extracts load data from the captured request afterwards.
   assign sel_is_store = (state == ST_IDLE) ? i_is_store : is_store_q;
   assign sel_funct3   = (state == ST_IDLE) ? i_funct3   : funct3_q;
   assign sel_addr_lo  = (state == ST_IDLE) ? i_addr[1:0] : addr_lo_q;

   lsu_align u_align (
      .is_store    (sel_is_store),
      .funct3      (sel_funct3),
      .addr_lo     (sel_addr_lo),
      .wdata       (i_wdata),
      .mem_rdata   (i_mem_rdata),
      .misaligned  (al_misaligned),
      .wstrb       (al_wstrb),
      .wdata_lanes (al_wdata),
      .rdata_ext   (al_rdata)
   );

   assign o_ready = (state == ST_IDLE);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state        <= ST_IDLE;
         is_store_q   <= 1'b0;
         funct3_q     <= 3'b000;
         addr_lo_q    <= 2'b00;
         o_mem_valid  <= 1'b0;
         o_mem_addr   <= 32'h0;
         o_mem_we     <= 1'b0;
         o_mem_wstrb  <= 4'b0000;
         o_mem_wdata  <= 32'h0;
         o_done       <= 1'b0;
         o_rdata      <= 32'h0;
         o_misaligned <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_valid) begin
                  is_store_q <= i_is_store;
                  funct3_q   <= i_funct3;
                  addr_lo_q  <= i_addr[1:0];
                  o_mem_addr <= {i_addr[31:2], 2'b00};
                  o_mem_wdata <= al_wdata;
                  if (al_misaligned) begin
                     state        <= ST_DONE;
                     o_done       <= 1'b1;
                     o_misaligned <= 1'b1;
                     o_mem_we     <= 1'b0;
                     o_mem_wstrb  <= 4'b0000;
                  end else begin
                     state        <= ST_REQ;
                     o_mem_valid  <= 1'b1;
                     o_misaligned <= 1'b0;
                     o_mem_we     <= i_is_store;
                     o_mem_wstrb  <= i_is_store ? al_wstrb : 4'b0000;
                  end
               end
            end
            ST_REQ: begin
               if (i_mem_ready) begin
                  o_mem_valid <= 1'b0;
                  if (is_store_q) begin
                     state  <= ST_DONE;
                     o_done <= 1'b1;
                  end else begin
                     state <= ST_RSP;
                  end
               end
            end
            ST_RSP: begin
               if (i_mem_rvalid) begin
                  o_rdata <= al_rdata;
                  state   <= ST_DONE;
                  o_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               state        <= ST_IDLE;
               o_misaligned <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic        i_is_store;
   logic [2:0]  i_funct3;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic        o_mem_valid;
   logic        i_mem_ready;
   logic [31:0] o_mem_addr;
   logic        o_mem_we;
   logic [3:0]  o_mem_wstrb;
   logic [31:0] o_mem_wdata;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;
   logic        o_done;
   logic [31:0] o_rdata;
   logic        o_misaligned;

   load_store_unit dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_is_store   (i_is_store),
      .i_funct3     (i_funct3),
      .i_addr       (i_addr),
      .i_wdata      (i_wdata),
      .o_mem_valid  (o_mem_valid),
      .i_mem_ready  (i_mem_ready),
      .o_mem_addr   (o_mem_addr),
      .o_mem_we     (o_mem_we),
      .o_mem_wstrb  (o_mem_wstrb),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_rvalid (i_mem_rvalid),
      .i_mem_rdata  (i_mem_rdata),
      .o_done       (o_done),
      .o_rdata      (o_rdata),
      .o_misaligned (o_misaligned)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      logic        mis;
      logic [31:0] rdata;
   } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];

   int errors = 0;
   int checks = 0;
   logic [31:0] last_rdata = 32'h0;

   // memory responder configuration for the current operation
   int          cfg_rd = 0;
   int          cfg_vd = 0;
   logic [31:0] cfg_rdata = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int op_width(input logic [2:0] f3);
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic logic exp_mis(input logic st, input logic [2:0] f3, input logic [31:0] addr);
      logic legal;
      if (st) legal = (f3 <= 3'd2);
      else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      return !legal || ((addr % op_width(f3)) != 0);
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] word);
      logic [31:0] v;
      int off;
      off = int'(addr % 4);
      v = word >> (8 * off);
      if (op_width(f3) == 1) begin
         v = v % 256;
         if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (op_width(f3) == 2) begin
         v = v % 65536;
         if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
         v = word;
      end
      return v;
   endfunction

   function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] addr);
      int off;
      off = int'(addr % 4);
      if (op_width(f3) == 1) return 4'(1 << off);
      if (op_width(f3) == 2) return 4'(3 << off);
      return 4'hF;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
      if (op_width(f3) == 1) return (wd % 256) * 32'h0101_0101;
      if (op_width(f3) == 2) return (wd % 65536) * 32'h0001_0001;
      return wd;
   endfunction

   // ---------------- memory responder ----------------
   logic pending = 1'b0;
   logic hs_load_nxt = 1'b0;
   logic rv_nxt = 1'b0;
   int   req_cnt = 0;
   int   rsp_cnt = 0;

   always @(posedge i_clk) begin
      #1;
      if (hs_load_nxt) begin
         pending = 1'b1;
         rsp_cnt = 0;
      end else if (rv_nxt) begin
         pending = 1'b0;
      end
      if (o_mem_valid) begin
         i_mem_ready = (req_cnt >= cfg_rd);
         req_cnt++;
      end else begin
         req_cnt = 0;
         i_mem_ready = ($urandom_range(0, 3) == 0);
      end
      if (pending) begin
         i_mem_rvalid = (rsp_cnt >= cfg_vd);
         i_mem_rdata  = i_mem_rvalid ? cfg_rdata : $urandom;
         rsp_cnt++;
      end else begin
         // stray responses outside RSP must be ignored
         i_mem_rvalid = ($urandom_range(0, 3) == 0);
         i_mem_rdata  = $urandom;
      end
      hs_load_nxt = o_mem_valid && i_mem_ready && !o_mem_we;
      rv_nxt      = pending && i_mem_rvalid;
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge i_clk) begin
      if (i_rst_n) begin
         if (o_mem_valid) begin
            if (req_q.size() == 0) begin
               check("unexpected_mem_valid", 32'(o_mem_valid), 32'h0);
            end else begin
               check("req_addr", o_mem_addr, req_q[0].addr);
               check("req_we", 32'(o_mem_we), 32'(req_q[0].we));
               if (req_q[0].we) begin
                  check("req_wstrb", 32'(o_mem_wstrb), 32'(req_q[0].wstrb));
                  check("req_wdata", o_mem_wdata, req_q[0].wdata);
               end
               if (i_mem_ready) void'(req_q.pop_front());
            end
         end
         if (o_done) begin
            if (rsp_q.size() == 0) begin
               check("unexpected_done", 32'(o_done), 32'h0);
            end else begin
               check("rsp_misaligned", 32'(o_misaligned), 32'(rsp_q[0].mis));
               check("rsp_rdata", o_rdata, rsp_q[0].rdata);
               void'(rsp_q.pop_front());
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] rword, input int rd, input int vd);
      logic mis;
      int   exp_lat;
      int   n;
      int   w;
      req_t r;
      rsp_t p;
      mis = exp_mis(st, f3, addr);
      w = 0;
      while (!o_ready && w < 50) begin
         @(posedge i_clk); #1;
         w++;
      end
      if (w == 50) check("ready_timeout", 32'(o_ready), 32'h1);
      if (!mis) begin
         r.addr  = addr - (addr % 4);
         r.we    = st;
         r.wstrb = exp_strb(f3, addr);
         r.wdata = exp_wdata(f3, wd);
         req_q.push_back(r);
         if (!st) last_rdata = exp_load(f3, addr, rword);
      end
      p.mis   = mis;
      p.rdata = last_rdata;
      rsp_q.push_back(p);
      cfg_rd = rd;
      cfg_vd = vd;
      cfg_rdata = rword;
      i_valid = 1'b1;
      i_is_store = st;
      i_funct3 = f3;
      i_addr = addr;
      i_wdata = wd;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_is_store = 1'($urandom);
      i_funct3 = 3'($urandom);
      i_addr = $urandom;
      i_wdata = $urandom;
      exp_lat = mis ? 1 : (st ? 2 + rd : 3 + rd + vd);
      n = 1;
      while (!o_done && n < 200) begin
         @(posedge i_clk); #1;
         n++;
      end
      check("done_latency", 32'(n), 32'(exp_lat));
      @(posedge i_clk); #1;
      check("done_one_cycle", 32'(o_done), 32'h0);
      check("ready_after_done", 32'(o_ready), 32'h1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_is_store = 1'b0;
      i_funct3 = 3'd0;
      i_addr = 32'h0;
      i_wdata = 32'h0;
      i_mem_ready = 1'b0;
      i_mem_rvalid = 1'b0;
      i_mem_rdata = 32'h0;
      repeat (3) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      check("rst_ready", 32'(o_ready), 32'h1);
      check("rst_mem_valid", 32'(o_mem_valid), 32'h0);
      check("rst_mem_we", 32'(o_mem_we), 32'h0);
      check("rst_mem_wstrb", 32'(o_mem_wstrb), 32'h0);
      check("rst_done", 32'(o_done), 32'h0);
      check("rst_misaligned", 32'(o_misaligned), 32'h0);
      check("rst_rdata", o_rdata, 32'h0);

      // directed corner cases
      op(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0);
      op(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 0);
      op(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 0);
      op(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 0, 0);
      op(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
      op(1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 5, 0);
      op(1'b0, 3'b101, 32'h0000_0042, 32'h0, 32'h8001_7FFF, 1, 2);
      op(1'b0, 3'b001, 32'h0000_0042, 32'h0, 32'h8001_7FFF, 0, 3);
      op(1'b1, 3'b100, 32'h0000_0040, 32'h1, 32'h0, 0, 0);
      op(1'b0, 3'b011, 32'h0000_0040, 32'h0, 32'h0, 0, 0);

      // randomized operations
      for (int k = 0; k < 150; k++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a = a - (a % 4);
         op(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // reset while a load waits in RSP, followed by a late response
      op(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'hA5A5_5A5A, 0, 0);
      begin
         req_t r;
         r.addr = 32'h0000_0080;
         r.we = 1'b0;
         r.wstrb = 4'h0;
         r.wdata = 32'h0;
         req_q.push_back(r);
      end
      cfg_rd = 0;
      cfg_vd = 4;
      cfg_rdata = 32'h1357_9BDF;
      i_valid = 1'b1;
      i_is_store = 1'b0;
      i_funct3 = 3'b010;
      i_addr = 32'h0000_0080;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      @(posedge i_clk); #1;
      check("rsp_wait_not_done", 32'(o_done), 32'h0);
      check("rsp_wait_busy", 32'(o_ready), 32'h0);
      i_rst_n = 1'b0;
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      req_q.delete();
      rsp_q.delete();
      last_rdata = 32'h0;
      check("midrst_ready", 32'(o_ready), 32'h1);
      check("midrst_mem_valid", 32'(o_mem_valid), 32'h0);
      check("midrst_rdata", o_rdata, 32'h0);
      for (int c = 0; c < 8; c++) begin
         @(posedge i_clk); #1;
         check("stray_rvalid_done", 32'(o_done), 32'h0);
         check("stray_rvalid_rdata", o_rdata, 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
